// File: rtl/lcd_capture.sv
// Captures the Game Boy LCD pixel stream into a double-buffered 2-bit framebuffer,
// tracking line/frame position from PPU mode edges and blanking on LCD off.
module lcd_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        lcd_on,
    input  logic        lcd_clkena,
    input  logic [1:0]  lcd_data,
    input  logic [1:0]  lcd_mode,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [1:0]  fb_data,
    output logic        rd_bank,
    output logic        frame_done,
    output logic        line_err
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    localparam logic [XW-1:0] X_MAX     = XW'(WIDTH);
    localparam logic [YW-1:0] Y_MAX     = YW'(HEIGHT);
    localparam logic [14:0]   LINE_STEP = 15'(WIDTH);
    localparam logic [14:0]   LAST_ADDR = 15'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        SYNC,
        CAPTURE,
        CLEAR,
        OFF
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [14:0]   base_q, base_d;
    logic [14:0]   clr_q, clr_d;
    logic          clr_last_q, clr_last_d;
    logic          wr_bank_q, wr_bank_d;
    logic [1:0]    mode_q, mode_d;
    logic          fb_we_q, fb_we_d;
    logic [15:0]   fb_addr_q, fb_addr_d;
    logic [1:0]    fb_data_q, fb_data_d;
    logic          rd_bank_q, rd_bank_d;
    logic          frame_done_q, frame_done_d;
    logic          line_err_q, line_err_d;

    logic line_end;
    logic vbl_entry;
    logic pix_acc;
    logic in_range;

    assign line_end  = (mode_q == 2'd3) && (lcd_mode != 2'd3);
    assign vbl_entry = (mode_q != 2'd1) && (lcd_mode == 2'd1);
    assign pix_acc   = ce && lcd_clkena && (lcd_mode == 2'd3);
    assign in_range  = (x_q < X_MAX) && (y_q < Y_MAX);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        base_d       = base_q;
        clr_d        = clr_q;
        clr_last_d   = clr_last_q;
        wr_bank_d    = wr_bank_q;
        mode_d       = ce ? lcd_mode : mode_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        rd_bank_d    = rd_bank_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;

        unique case (state_q)
            SYNC: begin
                if (ce) begin
                    if (!lcd_on) begin
                        state_d    = CLEAR;
                        clr_d      = '0;
                        clr_last_d = 1'b0;
                    end else if (vbl_entry) begin
                        x_d     = '0;
                        y_d     = '0;
                        base_d  = '0;
                        state_d = CAPTURE;
                    end
                end
            end

            CAPTURE: begin
                if (ce) begin
                    if (pix_acc) begin
                        if (in_range) begin
                            fb_we_d   = 1'b1;
                            fb_addr_d = {wr_bank_q, base_q + 15'(x_q)};
                            fb_data_d = lcd_data;
                            x_d       = x_q + 1'b1;
                        end else begin
                            line_err_d = 1'b1;
                        end
                    end

                    if (!lcd_on) begin
                        state_d    = CLEAR;
                        clr_d      = '0;
                        clr_last_d = 1'b0;
                    end else begin
                        if (line_end) begin
                            if (x_q != X_MAX) line_err_d = 1'b1;
                            x_d = '0;
                            if (y_q != Y_MAX) begin
                                y_d    = y_q + 1'b1;
                                base_d = base_q + LINE_STEP;
                            end
                        end
                        // y_d already includes a coincident line end
                        if (vbl_entry) begin
                            if (y_d != Y_MAX) line_err_d = 1'b1;
                            rd_bank_d    = wr_bank_q;
                            wr_bank_d    = ~wr_bank_q;
                            frame_done_d = 1'b1;
                            x_d          = '0;
                            y_d          = '0;
                            base_d       = '0;
                        end
                    end
                end
            end

            CLEAR: begin
                if (clr_last_q) begin
                    rd_bank_d    = wr_bank_q;
                    wr_bank_d    = ~wr_bank_q;
                    frame_done_d = 1'b1;
                    clr_last_d   = 1'b0;
                    state_d      = OFF;
                end else begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = {wr_bank_q, clr_q};
                    fb_data_d = 2'd0;
                    clr_d     = clr_q + 1'b1;
                    if (clr_q == LAST_ADDR) clr_last_d = 1'b1;
                end
            end

            OFF: begin
                if (ce && lcd_on) state_d = SYNC;
            end

            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= SYNC;
            x_q          <= '0;
            y_q          <= '0;
            base_q       <= '0;
            clr_q        <= '0;
            clr_last_q   <= 1'b0;
            wr_bank_q    <= 1'b0;
            mode_q       <= 2'd1;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            rd_bank_q    <= 1'b1;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            base_q       <= base_d;
            clr_q        <= clr_d;
            clr_last_q   <= clr_last_d;
            wr_bank_q    <= wr_bank_d;
            mode_q       <= mode_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            rd_bank_q    <= rd_bank_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign rd_bank    = rd_bank_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;

endmodule
